// File: rtl/cbm2_cycle_sched.sv
// Purpose : CBM-II bus slot scheduler. Walks a 16-slot (Professional) or 18-slot (Business) frame
//           and derives the EXT/CPU/COP/VID slot classes, CPU/IO/video strobes and refresh pacing.
// Latency : slot state is registered; class flags and strobes are combinational from that state.
// Backpressure: none; pause only acts at refresh sample points, one every 8 frames.
//
// Ports:
//   clk_sys, reset       clock; synchronous active-high reset
//   model                0 = Professional (slots 0..15), 1 = Business (slots 0..17)
//   turbo, io_slow       2MHz CPU request on Professional; io_slow blocks it for 1MHz devices
//   copro_en, pause      coprocessor present; freeze request
//   cycle, phase         effective slot index (0 while frozen); frame parity
//   sys_enable, refresh  run state; one-clk refresh pulse
//   io_cycle, cpu_cycle, vid_cycle                     slot-class flags
//   en_cpu, en_io_n, en_io_p, en_vic, en_crtc, en_pixel single-clk strobes
//
// Build option: define CBM2_SCHED_TURBO_EN to honour turbo on Professional. Without it the
// CPU runs at full rate only on Business, and turbo/io_slow have no effect.

module cbm2_cycle_sched (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       model,
  input  logic       turbo,
  input  logic       copro_en,
  input  logic       io_slow,
  input  logic       pause,
  output logic [4:0] cycle,
  output logic       phase,
  output logic       sys_enable,
  output logic       refresh,
  output logic       io_cycle,
  output logic       cpu_cycle,
  output logic       vid_cycle,
  output logic       en_cpu,
  output logic       en_io_n,
  output logic       en_io_p,
  output logic       en_vic,
  output logic       en_crtc,
  output logic       en_pixel
);

  logic [4:0] counter_q, counter_d;
  logic       phase_q, phase_d;
  logic [2:0] rfsh_q, rfsh_d;
  logic       sys_enable_q, sys_enable_d;
  logic       refresh_q, refresh_d;
  logic [1:0] pix_q, pix_d;

  logic [4:0] end_slot;
  logic       frame_wrap;
  logic       fast;
  logic       cpu_go;
  logic       slot_ext, slot_cpu, slot_cop, slot_vid;

  assign end_slot = model ? 5'd17 : 5'd15;
  // ">=" also catches a switch to Professional while sitting in slot 16/17:
  // that ends the frame immediately, with the usual frame-end bookkeeping.
  assign frame_wrap = (counter_q >= end_slot);

`ifdef CBM2_SCHED_TURBO_EN
  assign fast = model | (turbo & ~io_slow);
`else
  // turbo/io_slow stay on the port list for board compatibility but drive nothing.
  logic unused_turbo_inputs;
  assign unused_turbo_inputs = turbo ^ io_slow;
  assign fast = model;
`endif

  always_comb begin
    counter_d    = counter_q;
    phase_d      = phase_q;
    rfsh_d       = rfsh_q;
    sys_enable_d = sys_enable_q;
    refresh_d    = 1'b0;
    pix_d        = pix_q;
    if (reset) begin
      counter_d    = 5'd0;
      phase_d      = 1'b0;
      rfsh_d       = 3'd0;
      sys_enable_d = 1'b1;
      pix_d        = 2'd0;
    end else begin
      counter_d = frame_wrap ? 5'd0 : counter_q + 5'd1;
      if (frame_wrap) begin
        phase_d = ~phase_q;
        rfsh_d  = rfsh_q + 3'd1;
        // Refresh frame: the only point where pause is looked at, so freeze and
        // resume both land on 8-frame boundaries.
        if (rfsh_q == 3'd0) begin
          sys_enable_d = ~pause;
          refresh_d    = 1'b1;
        end
      end
      // Pixel divider is realigned to the frame start and held while frozen.
      if (!sys_enable_q || (cycle == end_slot)) begin
        pix_d = 2'd0;
      end else begin
        pix_d = pix_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    counter_q    <= counter_d;
    phase_q      <= phase_d;
    rfsh_q       <= rfsh_d;
    sys_enable_q <= sys_enable_d;
    refresh_q    <= refresh_d;
    pix_q        <= pix_d;
  end

  // While frozen the bus sits in slot 0, which keeps every CPU/video strobe quiet.
  assign cycle      = sys_enable_q ? counter_q : 5'd0;
  assign phase      = phase_q;
  assign sys_enable = sys_enable_q;
  assign refresh    = refresh_q;

  assign slot_ext = (cycle <= 5'd3);
  assign slot_cpu = (cycle >= 5'd4) && (cycle <= 5'd7);
  assign slot_cop = (cycle >= 5'd8) && (cycle <= 5'd11);
  assign slot_vid = (cycle >= 5'd12);

  // Slow CPU gets its slots only on odd frames; fast CPU gets them every frame.
  assign cpu_go = phase_q | fast;

  // The coprocessor borrows the EXT slots on even frames, so IO is pushed to odd frames.
  assign cpu_cycle = (slot_cpu & cpu_go) | (slot_cop & copro_en) | (slot_ext & copro_en & ~phase_q);
  assign io_cycle  = slot_ext & (rfsh_q != 3'd1) & (phase_q | ~copro_en);
  assign vid_cycle = slot_vid;

  assign en_io_n  = ~reset & (cycle == 5'd6) & cpu_go;
  assign en_cpu   = ~reset & (cycle == 5'd7) & cpu_go;
  assign en_io_p  = ~reset & (cycle == 5'd8) & cpu_go;
  assign en_vic   = ~reset & (cycle == 5'd15) & ~model;
  assign en_crtc  = ~reset & (cycle == 5'd11) & model;
  assign en_pixel = ~reset & (pix_q == 2'd3);

endmodule

// File: tb/tb_cbm2_cycle_sched.sv
// Purpose : directed self-checking bench for cbm2_cycle_sched.
// Latency : inputs change and outputs are sampled on the falling edge of clk_sys.
// Backpressure: n/a.

module tb_cbm2_cycle_sched;

  logic       clk_sys = 1'b0;
  logic       reset, model, turbo, copro_en, io_slow, pause;
  logic [4:0] cycle;
  logic       phase, sys_enable, refresh, io_cycle, cpu_cycle, vid_cycle;
  logic       en_cpu, en_io_n, en_io_p, en_vic, en_crtc, en_pixel;

  int vectors = 0;
  int miscompares = 0;

`ifdef CBM2_SCHED_TURBO_EN
  localparam bit TURBO_BUILD = 1'b1;
`else
  localparam bit TURBO_BUILD = 1'b0;
`endif

  always #5 clk_sys = ~clk_sys;

  cbm2_cycle_sched dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .model      (model),
    .turbo      (turbo),
    .copro_en   (copro_en),
    .io_slow    (io_slow),
    .pause      (pause),
    .cycle      (cycle),
    .phase      (phase),
    .sys_enable (sys_enable),
    .refresh    (refresh),
    .io_cycle   (io_cycle),
    .cpu_cycle  (cpu_cycle),
    .vid_cycle  (vid_cycle),
    .en_cpu     (en_cpu),
    .en_io_n    (en_io_n),
    .en_io_p    (en_io_p),
    .en_vic     (en_vic),
    .en_crtc    (en_crtc),
    .en_pixel   (en_pixel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  initial begin
    int c, p, r, n_cpu;
    bit se;

    reset = 1'b1; model = 1'b0; turbo = 1'b0; copro_en = 1'b0; io_slow = 1'b0; pause = 1'b0;
    adv(2);
    chk("rst_cycle", 32'(cycle), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_sys_enable", 32'(sys_enable), 1);
    chk("rst_refresh", 32'(refresh), 0);
    chk("rst_strobes", 32'({en_cpu, en_io_n, en_io_p, en_vic, en_crtc, en_pixel}), 0);
    reset = 1'b0;
    #1;
    chk("rel_cycle", 32'(cycle), 0);
    chk("rel_phase", 32'(phase), 0);

    // Professional, slow CPU, no coprocessor: two frames
    n_cpu = 0;
    for (int k = 1; k <= 32; k++) begin
      adv(1);
      c = k % 16; p = (k / 16) % 2; r = k / 16;
      chk("pro_cycle", 32'(cycle), 32'(c));
      chk("pro_phase", 32'(phase), 32'(p));
      chk("pro_en_cpu", 32'(en_cpu), 32'(c == 7 && p == 1));
      chk("pro_en_io_n", 32'(en_io_n), 32'(c == 6 && p == 1));
      chk("pro_en_io_p", 32'(en_io_p), 32'(c == 8 && p == 1));
      chk("pro_en_vic", 32'(en_vic), 32'(c == 15));
      chk("pro_en_crtc", 32'(en_crtc), 0);
      chk("pro_refresh", 32'(refresh), 32'(k == 16));
      chk("pro_en_pixel", 32'(en_pixel), 32'(c % 4 == 3));
      chk("pro_io_cycle", 32'(io_cycle), 32'(c <= 3 && r != 1));
      if (en_cpu) n_cpu++;
    end
    chk("pro_en_cpu_count", 32'(n_cpu), 1);

    // Business: 18-slot frames, CPU every frame; rfsh runs 2 -> 4
    model = 1'b1;
    n_cpu = 0;
    for (int j = 1; j <= 36; j++) begin
      adv(1);
      c = j % 18; p = (j / 18) % 2;
      chk("bus_cycle", 32'(cycle), 32'(c));
      chk("bus_phase", 32'(phase), 32'(p));
      chk("bus_en_cpu", 32'(en_cpu), 32'(c == 7));
      chk("bus_en_crtc", 32'(en_crtc), 32'(c == 11));
      chk("bus_en_vic", 32'(en_vic), 0);
      chk("bus_en_pixel", 32'(en_pixel), 32'(c % 4 == 3));
      chk("bus_refresh", 32'(refresh), 0);
      if (en_cpu) n_cpu++;
    end
    chk("bus_en_cpu_count", 32'(n_cpu), 2);

    // Business with coprocessor, eight frames so rfsh passes through 0 and 1
    copro_en = 1'b1;
    for (int j = 1; j <= 144; j++) begin
      adv(1);
      c = j % 18; p = (j / 18) % 2; r = (4 + j / 18) % 8;
      chk("cop_phase", 32'(phase), 32'(p));
      chk("cop_cpu_cycle", 32'(cpu_cycle), 32'((c >= 4 && c <= 11) || (c <= 3 && p == 0)));
      chk("cop_io_cycle", 32'(io_cycle), 32'(c <= 3 && p == 1 && r != 1));
      chk("cop_vid_cycle", 32'(vid_cycle), 32'(c >= 12));
      chk("cop_refresh", 32'(refresh), 32'(c == 0 && r == 1));
    end

    // Professional with turbo, first io_slow=0 then io_slow=1
    copro_en = 1'b0; model = 1'b0; turbo = 1'b1; io_slow = 1'b0;
    n_cpu = 0;
    for (int k = 1; k <= 32; k++) begin
      adv(1);
      c = k % 16; p = (k / 16) % 2;
      chk("tur_cycle", 32'(cycle), 32'(c));
      chk("tur_en_cpu", 32'(en_cpu), 32'(c == 7 && (p == 1 || TURBO_BUILD)));
      chk("tur_en_io_p", 32'(en_io_p), 32'(c == 8 && (p == 1 || TURBO_BUILD)));
      if (en_cpu) n_cpu++;
    end
    chk("tur_en_cpu_count", 32'(n_cpu), TURBO_BUILD ? 2 : 1);
    io_slow = 1'b1;
    n_cpu = 0;
    for (int k = 33; k <= 64; k++) begin
      adv(1);
      c = k % 16; p = (k / 16) % 2;
      chk("slow_en_cpu", 32'(en_cpu), 32'(c == 7 && p == 1));
      chk("slow_en_io_n", 32'(en_io_n), 32'(c == 6 && p == 1));
      if (en_cpu) n_cpu++;
    end
    chk("slow_en_cpu_count", 32'(n_cpu), 1);
    turbo = 1'b0; io_slow = 1'b0;

    // Model switch 1->0 in slot 17; rfsh is 0 here so the forced wrap also refreshes
    model = 1'b1;
    adv(17);
    chk("sw_cycle17", 32'(cycle), 17);
    chk("sw_phase_before", 32'(phase), 0);
    model = 1'b0;
    adv(1);
    chk("sw_cycle_wrap", 32'(cycle), 0);
    chk("sw_phase_after", 32'(phase), 1);
    chk("sw_refresh", 32'(refresh), 1);
    adv(1);
    chk("sw_cycle1", 32'(cycle), 1);
    chk("sw_phase_hold", 32'(phase), 1);

    // Strobe gating by reset, then reset taken in slot 9
    adv(6);
    chk("gate_en_cpu_live", 32'(en_cpu), 1);
    reset = 1'b1;
    #1;
    chk("gate_en_cpu_rst", 32'(en_cpu), 0);
    reset = 1'b0;
    adv(2);
    chk("midrst_cycle9", 32'(cycle), 9);
    chk("midrst_phase", 32'(phase), 1);
    reset = 1'b1;
    adv(1);
    chk("midrst_cycle0", 32'(cycle), 0);
    chk("midrst_phase0", 32'(phase), 0);
    chk("midrst_sys_enable", 32'(sys_enable), 1);
    chk("midrst_strobes", 32'({en_cpu, en_io_n, en_io_p, en_vic, en_crtc, en_pixel}), 0);
    reset = 1'b0;

    // Pause raised after the first refresh sample: freeze at edge 144, release at edge 272
    for (int t = 1; t <= 290; t++) begin
      pause = (t >= 20 && t < 150);
      adv(1);
      se = !(t >= 144 && t < 272);
      c = se ? t % 16 : 0; p = (t / 16) % 2; r = (t / 16) % 8;
      chk("pz_sys_enable", 32'(se ? 1 : 0), 32'(sys_enable));
      chk("pz_refresh", 32'(refresh), 32'(t == 16 || t == 144 || t == 272));
      chk("pz_cycle", 32'(cycle), 32'(c));
      chk("pz_en_cpu", 32'(en_cpu), 32'(se && c == 7 && p == 1));
      chk("pz_en_pixel", 32'(en_pixel), 32'(se && c % 4 == 3));
      chk("pz_io_cycle", 32'(io_cycle), 32'(c <= 3 && r != 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
